// File: rtl/fu_md_iter.sv
// fu_md_iter: iterative multiply/divide functional unit.
//   Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on a single shared
//   32-iteration shift datapath: shift-add for products, restoring division for
//   quotient/remainder. One op in flight; flush kills it.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              kill in-flight op, return to IDLE next cycle
//   iss_*              issue handshake and uop fields from the reservation station
//   cdb_*              result lane with valid/ready backpressure, plus captured fields
module fu_md_iter #(
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [ROB_IDX-1:0] iss_rob_id,
  input  logic [ARF_IDX-1:0] iss_rd_arch,
  input  logic [PRF_IDX-1:0] iss_rd_phy,
  input  logic [3:0]         iss_fu_opcode,
  input  logic [31:0]        iss_rs1_value,
  input  logic [31:0]        iss_rs2_value,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [ROB_IDX-1:0] cdb_rob_id,
  output logic [ARF_IDX-1:0] cdb_rd_arch,
  output logic [PRF_IDX-1:0] cdb_rd_phy,
  output logic [31:0]        cdb_rd_value,
  output logic [31:0]        cdb_rs1_value_dbg,
  output logic [31:0]        cdb_rs2_value_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  count;
  logic [2:0]  op_r;     // normalised opcode of the op in flight
  logic        neg_r;    // final result must be negated
  logic [31:0] b_r;      // multiplicand (mul) or divisor magnitude (div)
  logic [63:0] acc_r;    // {hi, lo}: product accumulator or {remainder, quotient}

  // ---------------- issue-side decode ----------------
  logic [2:0]  iss_op;
  logic        s1_signed, s2_signed, neg1, neg2;
  logic [31:0] mag1, mag2;
  logic        special;
  logic [31:0] special_res;
  logic        iss_neg;
  logic [63:0] iss_acc;
  logic [31:0] iss_b;

  always_comb begin
    // Opcodes 8..15 execute as MUL.
    iss_op      = iss_fu_opcode[3] ? 3'd0 : iss_fu_opcode[2:0];
    s1_signed   = (iss_op == 3'd1) || (iss_op == 3'd2) || (iss_op == 3'd4) || (iss_op == 3'd6);
    s2_signed   = (iss_op == 3'd1) || (iss_op == 3'd4) || (iss_op == 3'd6);
    neg1        = s1_signed && iss_rs1_value[31];
    neg2        = s2_signed && iss_rs2_value[31];
    mag1        = neg1 ? -iss_rs1_value : iss_rs1_value;
    mag2        = neg2 ? -iss_rs2_value : iss_rs2_value;
    special     = 1'b0;
    special_res = '0;
    if (iss_op[2]) begin
      if (iss_rs2_value == '0) begin
        special     = 1'b1;
        special_res = iss_op[1] ? iss_rs1_value : 32'hFFFF_FFFF;
      end else if (!iss_op[0] && iss_rs1_value == 32'h8000_0000 &&
                   iss_rs2_value == 32'hFFFF_FFFF) begin
        special     = 1'b1;
        special_res = iss_op[1] ? 32'h0 : 32'h8000_0000;
      end
    end
    // Remainder follows the dividend sign; product/quotient follow the sign difference.
    iss_neg = (iss_op[2] && iss_op[1]) ? neg1 : (neg1 ^ neg2);
    if (iss_op[2]) begin
      iss_acc = {32'h0, mag1};
      iss_b   = mag2;
    end else begin
      iss_acc = {32'h0, mag2};
      iss_b   = mag1;
    end
  end

  // ---------------- one iteration of the shared datapath ----------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_r} : 33'h0);
    mul_next  = {mul_sum, acc_r[31:1]};
    // Shift the next dividend bit into the partial remainder and try subtracting.
    div_trial = {1'b0, acc_r[63:32], acc_r[31]} - {2'b00, b_r};
    if (div_trial[33])
      div_next = {acc_r[62:0], 1'b0};
    else
      div_next = {div_trial[31:0], acc_r[30:0], 1'b1};
    acc_next  = op_r[2] ? div_next : mul_next;
  end

  // ---------------- final result from the last iteration ----------------
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] calc_result;

  always_comb begin
    prod_fix = neg_r ? -acc_next : acc_next;
    quo_fix  = neg_r ? -acc_next[31:0]  : acc_next[31:0];
    rem_fix  = neg_r ? -acc_next[63:32] : acc_next[63:32];
    if (op_r[2])
      calc_result = op_r[1] ? rem_fix : quo_fix;
    else
      calc_result = (op_r[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // ---------------- FSM ----------------
  logic iss_fire;

  always_comb begin
    iss_fire = (state == S_IDLE) && iss_valid && !flush;
    state_nx = state;
    case (state)
      S_IDLE: if (iss_valid) state_nx = special ? S_DONE : S_CALC;
      S_CALC: if (count == 5'd31) state_nx = S_DONE;
      S_DONE: if (cdb_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  assign iss_ready = (state == S_IDLE);
  assign cdb_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      count             <= '0;
      op_r              <= '0;
      neg_r             <= 1'b0;
      b_r               <= '0;
      acc_r             <= '0;
      cdb_rob_id        <= '0;
      cdb_rd_arch       <= '0;
      cdb_rd_phy        <= '0;
      cdb_rd_value      <= '0;
      cdb_rs1_value_dbg <= '0;
      cdb_rs2_value_dbg <= '0;
    end else begin
      state <= state_nx;
      if (iss_fire) begin
        count             <= '0;
        op_r              <= iss_op;
        neg_r             <= iss_neg;
        b_r               <= iss_b;
        acc_r             <= iss_acc;
        cdb_rob_id        <= iss_rob_id;
        cdb_rd_arch       <= iss_rd_arch;
        cdb_rd_phy        <= iss_rd_phy;
        cdb_rs1_value_dbg <= iss_rs1_value;
        cdb_rs2_value_dbg <= iss_rs2_value;
        if (special) cdb_rd_value <= special_res;
      end else if (state == S_CALC && !flush) begin
        acc_r <= acc_next;
        count <= count + 5'd1;
        if (count == 5'd31) cdb_rd_value <= calc_result;
      end
    end
  end

endmodule

// File: tb/tb_fu_md_iter.sv
// tb_fu_md_iter: directed self-checking bench for fu_md_iter.
module tb_fu_md_iter;

  localparam logic [3:0] MD_MUL = 4'd0, MD_MULH = 4'd1, MD_MULHSU = 4'd2, MD_MULHU = 4'd3,
                         MD_DIV = 4'd4, MD_DIVU = 4'd5, MD_REM = 4'd6, MD_REMU = 4'd7;

  logic        clk = 1'b0;
  logic        rst, flush, iss_valid, iss_ready, cdb_valid, cdb_ready;
  logic [4:0]  iss_rob_id, cdb_rob_id;
  logic [4:0]  iss_rd_arch, cdb_rd_arch;
  logic [5:0]  iss_rd_phy, cdb_rd_phy;
  logic [3:0]  iss_fu_opcode;
  logic [31:0] iss_rs1_value, iss_rs2_value;
  logic [31:0] cdb_rd_value, cdb_rs1_value_dbg, cdb_rs2_value_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int tag_id   = 0;
  logic [4:0]  cur_rob, cur_arch;
  logic [5:0]  cur_phy;
  logic [31:0] cur_a, cur_b;

  always #5 clk = ~clk;

  fu_md_iter #(.ROB_IDX(5), .PRF_IDX(6), .ARF_IDX(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rob_id(iss_rob_id), .iss_rd_arch(iss_rd_arch), .iss_rd_phy(iss_rd_phy),
    .iss_fu_opcode(iss_fu_opcode), .iss_rs1_value(iss_rs1_value), .iss_rs2_value(iss_rs2_value),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rob_id(cdb_rob_id), .cdb_rd_arch(cdb_rd_arch), .cdb_rd_phy(cdb_rd_phy),
    .cdb_rd_value(cdb_rd_value), .cdb_rs1_value_dbg(cdb_rs1_value_dbg),
    .cdb_rs2_value_dbg(cdb_rs2_value_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one issue beat; returns just after the accepting edge.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("iss_ready_before_issue", iss_ready, 1);
    tag_id++;
    cur_rob  = 5'(tag_id);
    cur_arch = 5'(tag_id + 3);
    cur_phy  = 6'(tag_id + 17);
    cur_a = a;
    cur_b = b;
    iss_valid = 1'b1; iss_fu_opcode = op; iss_rs1_value = a; iss_rs2_value = b;
    iss_rob_id = cur_rob; iss_rd_arch = cur_arch; iss_rd_phy = cur_phy;
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    iss_rs1_value = 32'hDEAD_BEEF; iss_rs2_value = 32'h1234_5678;
    iss_rob_id = '1; iss_rd_arch = '1; iss_rd_phy = '1;
  endtask

  // Waits for the result, checks latency/fields, holds backpressure, then consumes.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int exp_lat,
                           input int hold);
    int lat = 1;
    @(negedge clk);
    while (!cdb_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_value"}, cdb_rd_value, exp);
    check({tag, "_rob"}, cdb_rob_id, cur_rob);
    check({tag, "_arch_phy"}, {cdb_rd_arch, cdb_rd_phy}, {cur_arch, cur_phy});
    check({tag, "_dbg"}, {cdb_rs1_value_dbg, cdb_rs2_value_dbg}, {cur_a, cur_b});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid_ready"}, {cdb_valid, iss_ready}, 2'b10);
      check({tag, "_hold_value"}, cdb_rd_value, exp);
      check({tag, "_hold_fields"}, {cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rs1_value_dbg},
            {cur_rob, cur_arch, cur_phy, cur_a});
      check({tag, "_hold_rs2"}, cdb_rs2_value_dbg, cur_b);
    end
    cdb_ready = 1'b1;
    @(posedge clk);
    #1;
    cdb_ready = 1'b0;
    check({tag, "_after_handshake"}, {cdb_valid, iss_ready}, 2'b01);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    start_op(op, a, b);
    finish_op(tag, exp, exp_lat, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; cdb_ready = 1'b0;
    iss_rob_id = '0; iss_rd_arch = '0; iss_rd_phy = '0; iss_fu_opcode = '0;
    iss_rs1_value = '0; iss_rs2_value = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid_ready", {cdb_valid, iss_ready}, 2'b01);
    check("reset_value", cdb_rd_value, 0);
    check("reset_fields", {cdb_rob_id, cdb_rd_arch, cdb_rd_phy}, 0);
    check("reset_dbg", {cdb_rs1_value_dbg, cdb_rs2_value_dbg}, 0);

    // Main function
    do_op("mul",       MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulh",      MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("mulhu",     MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulhsu",    MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("mulh_mix",  MD_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);
    do_op("op8_mul",   4'd8,      32'd6,         32'd7,         32'd42,        33);
    do_op("div",       MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("rem",       MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("divu",      MD_DIVU,   32'd100,       32'd7,         32'd14,        33);
    do_op("remu",      MD_REMU,   32'd100,       32'd7,         32'd2,         33);
    do_op("divu_big",  MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
    do_op("remu_big",  MD_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    // Special cases
    do_op("div_by0",   MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("rem_by0",   MD_REM,    32'd5,         32'd0,         32'd5,         1);
    do_op("divu_by0",  MD_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("div_ovf",   MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",   MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Backpressure in DONE
    start_op(MD_MUL, 32'd1000, 32'd1000);
    finish_op("bp", 32'd1000000, 33, 5);

    // Flush at count 10; a coincident issue must not be captured
    start_op(MD_MUL, 32'd7, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; iss_valid = 1'b1; iss_fu_opcode = MD_DIVU;
    iss_rs1_value = 32'd50; iss_rs2_value = 32'd0;
    @(posedge clk);
    #1;
    flush = 1'b0; iss_valid = 1'b0;
    check("flush_idle", {cdb_valid, iss_ready}, 2'b01);
    do_op("post_flush", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Same sequence with reset
    start_op(MD_MUL, 32'd7, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; iss_valid = 1'b1; iss_fu_opcode = MD_DIVU;
    iss_rs1_value = 32'd50; iss_rs2_value = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0; iss_valid = 1'b0;
    check("rst_idle", {cdb_valid, iss_ready}, 2'b01);
    check("rst_cleared", {cdb_rob_id, cdb_rd_value, cdb_rs1_value_dbg}, 0);
    do_op("post_rst", MD_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
